// File: rtl/cave_input_pkg.sv
// Shared types and constants for the Cave player-control front end:
// PS/2 scan codes, the player output struct and joystick bit positions.
package cave_input_pkg;

    localparam logic KEY_EXT = 1'b1;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_CTRL  = 8'h14;
    localparam logic [7:0] SC_ALT   = 8'h11;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_5     = 8'h2E;
    localparam logic [7:0] SC_6     = 8'h36;
    localparam logic [7:0] SC_9     = 8'h46;
    localparam logic [7:0] SC_0     = 8'h45;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_F     = 8'h2B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_G     = 8'h34;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_Q     = 8'h15;
    localparam logic [7:0] SC_P     = 8'h4D;

    typedef struct packed {
        logic coin;
        logic start;
        logic b3;
        logic b2;
        logic b1;
        logic right;
        logic left;
        logic down;
        logic up;
    } player_t;

    localparam int JOY_R     = 0;
    localparam int JOY_L     = 1;
    localparam int JOY_D     = 2;
    localparam int JOY_U     = 3;
    localparam int JOY_B1    = 4;
    localparam int JOY_B2    = 5;
    localparam int JOY_B3    = 6;
    localparam int JOY_START = 7;
    localparam int JOY_COIN  = 8;
    localparam int JOY_PAUSE = 9;
    localparam int JOY_SVC   = 10;

endpackage

// File: rtl/cave_input_ctrl_if.sv
// Bundle of the host-side inputs (PS/2, joysticks, vsync) and the
// player-control outputs handed on to Main.
interface cave_input_ctrl_if;
    import cave_input_pkg::*;

    logic [10:0] ps2_key;
    logic [10:0] joystick_0;
    logic [10:0] joystick_1;
    logic        vsync;
    player_t     p1_o;
    player_t     p2_o;
    logic [1:0]  service_o;
    logic        pause_o;

    modport master (
        output ps2_key, joystick_0, joystick_1, vsync,
        input  p1_o, p2_o, service_o, pause_o
    );

    modport slave (
        input  ps2_key, joystick_0, joystick_1, vsync,
        output p1_o, p2_o, service_o, pause_o
    );

endinterface

// File: rtl/cave_pulse_stretch.sv
// Turns a rising edge of trig into a q pulse lasting COIN_FRAMES rising
// edges of tick; edges arriving while a pulse runs are dropped.
module cave_pulse_stretch #(
    parameter int COIN_FRAMES = 4,
    parameter int COIN_W      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    input  logic tick,
    output logic q
);

    localparam logic [COIN_W-1:0] LOAD = COIN_W'(COIN_FRAMES);

    logic [COIN_W-1:0] cnt_q;
    logic [COIN_W-1:0] cnt_d;
    logic              trig_q;
    logic              tick_q;

    // A load can only happen at zero, so it always takes priority over a tick.
    always_comb begin
        cnt_d = cnt_q;
        if (trig && !trig_q && cnt_q == '0) begin
            cnt_d = LOAD;
        end else if (tick && !tick_q && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            trig_q <= 1'b0;
            tick_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            trig_q <= trig;
            tick_q <= tick;
            q      <= (cnt_d != '0);
        end
    end

endmodule

// File: rtl/cave_input_ctrl.sv
// Player-control front end: PS/2 key state, joystick merge, coin stretch
// and pause toggle, all outputs registered in the clk_sys domain.
module cave_input_ctrl
    import cave_input_pkg::*;
#(
    parameter int COIN_FRAMES = 4,
    parameter int COIN_W      = 4
) (
    input logic               clk,
    input logic               rst,
    cave_input_ctrl_if.slave  bus
);

    logic       tog_q;
    logic       ps2_evt;
    logic       ps2_prs;
    logic       ps2_ext;
    logic [7:0] ps2_code;

    player_t    key1;
    player_t    key2;
    logic [1:0] key_svc;
    logic       key_pause;

    player_t    raw1;
    player_t    raw2;
    logic [1:0] raw_svc;
    logic       raw_pause;

    logic [7:0] p1_q;
    logic [7:0] p2_q;
    logic [1:0] svc_q;
    logic       pause_q;
    logic       pause_prev;
    logic       coin1;
    logic       coin2;

    assign ps2_evt  = bus.ps2_key[10] ^ tog_q;
    assign ps2_prs  = bus.ps2_key[9];
    assign ps2_ext  = bus.ps2_key[8];
    assign ps2_code = bus.ps2_key[7:0];

    // Key register bank: one bit per mapped key, updated on each toggle event
    always_ff @(posedge clk) begin
        if (rst) begin
            tog_q     <= bus.ps2_key[10];
            key1      <= '0;
            key2      <= '0;
            key_svc   <= '0;
            key_pause <= 1'b0;
        end else begin
            tog_q <= bus.ps2_key[10];
            if (ps2_evt) begin
                if (ps2_ext == KEY_EXT) begin
                    case (ps2_code)
                        SC_UP:    key1.up    <= ps2_prs;
                        SC_DOWN:  key1.down  <= ps2_prs;
                        SC_LEFT:  key1.left  <= ps2_prs;
                        SC_RIGHT: key1.right <= ps2_prs;
                        default: ;
                    endcase
                end else begin
                    case (ps2_code)
                        SC_SPACE: key1.b3    <= ps2_prs;
                        SC_1:     key1.start <= ps2_prs;
                        SC_2:     key2.start <= ps2_prs;
                        SC_5:     key1.coin  <= ps2_prs;
                        SC_6:     key2.coin  <= ps2_prs;
                        SC_9:     key_svc[0] <= ps2_prs;
                        SC_0:     key_svc[1] <= ps2_prs;
                        SC_R:     key2.up    <= ps2_prs;
                        SC_F:     key2.down  <= ps2_prs;
                        SC_D:     key2.left  <= ps2_prs;
                        SC_G:     key2.right <= ps2_prs;
                        SC_A:     key2.b1    <= ps2_prs;
                        SC_S:     key2.b2    <= ps2_prs;
                        SC_Q:     key2.b3    <= ps2_prs;
                        SC_P:     key_pause  <= ps2_prs;
                        default: ;
                    endcase
                end
                // Ctrl and Alt exist on both sides of the keyboard.
                case (ps2_code)
                    SC_CTRL: key1.b1 <= ps2_prs;
                    SC_ALT:  key1.b2 <= ps2_prs;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        raw1.up    = key1.up    | bus.joystick_0[JOY_U];
        raw1.down  = key1.down  | bus.joystick_0[JOY_D];
        raw1.left  = key1.left  | bus.joystick_0[JOY_L];
        raw1.right = key1.right | bus.joystick_0[JOY_R];
        raw1.b1    = key1.b1    | bus.joystick_0[JOY_B1];
        raw1.b2    = key1.b2    | bus.joystick_0[JOY_B2];
        raw1.b3    = key1.b3    | bus.joystick_0[JOY_B3];
        raw1.start = key1.start | bus.joystick_0[JOY_START];
        raw1.coin  = key1.coin  | bus.joystick_0[JOY_COIN];
        raw2.up    = key2.up    | bus.joystick_1[JOY_U];
        raw2.down  = key2.down  | bus.joystick_1[JOY_D];
        raw2.left  = key2.left  | bus.joystick_1[JOY_L];
        raw2.right = key2.right | bus.joystick_1[JOY_R];
        raw2.b1    = key2.b1    | bus.joystick_1[JOY_B1];
        raw2.b2    = key2.b2    | bus.joystick_1[JOY_B2];
        raw2.b3    = key2.b3    | bus.joystick_1[JOY_B3];
        raw2.start = key2.start | bus.joystick_1[JOY_START];
        raw2.coin  = key2.coin  | bus.joystick_1[JOY_COIN];
        raw_svc    = key_svc | {bus.joystick_1[JOY_SVC], bus.joystick_0[JOY_SVC]};
        raw_pause  = key_pause | bus.joystick_0[JOY_PAUSE] | bus.joystick_1[JOY_PAUSE];
    end

    // Output register stage; pause edges from both players merge before detection
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_q       <= '0;
            p2_q       <= '0;
            svc_q      <= '0;
            pause_q    <= 1'b0;
            pause_prev <= 1'b0;
        end else begin
            p1_q       <= raw1[7:0];
            p2_q       <= raw2[7:0];
            svc_q      <= raw_svc;
            pause_prev <= raw_pause;
            if (raw_pause && !pause_prev) begin
                pause_q <= ~pause_q;
            end
        end
    end

    cave_pulse_stretch #(
        .COIN_FRAMES (COIN_FRAMES),
        .COIN_W      (COIN_W)
    ) u_coin1 (
        .clk  (clk),
        .rst  (rst),
        .trig (raw1.coin),
        .tick (bus.vsync),
        .q    (coin1)
    );

    cave_pulse_stretch #(
        .COIN_FRAMES (COIN_FRAMES),
        .COIN_W      (COIN_W)
    ) u_coin2 (
        .clk  (clk),
        .rst  (rst),
        .trig (raw2.coin),
        .tick (bus.vsync),
        .q    (coin2)
    );

    assign bus.p1_o      = {coin1, p1_q};
    assign bus.p2_o      = {coin2, p2_q};
    assign bus.service_o = svc_q;
    assign bus.pause_o   = pause_q;

endmodule

// File: tb/tb_cave_input_ctrl.sv
// Scenario bench for cave_input_ctrl: expected outputs and coin pulse
// widths are queued as stimulus is applied and checked as the DUT responds.
module tb_cave_input_ctrl;
    import cave_input_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cave_input_ctrl_if bif ();

    cave_input_ctrl #(
        .COIN_FRAMES (4),
        .COIN_W      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    int n_run  = 0;
    int n_fail = 0;

    logic [19:0] exp_q[$];
    int          pulse_q[$];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_key(input logic ext, input logic [7:0] code, input logic prs);
        bif.ps2_key = {~bif.ps2_key[10], prs, ext, code};
    endtask

    function automatic logic [19:0] out_vec();
        return {bif.p1_o, bif.p2_o, bif.service_o};
    endfunction

    task automatic run_frames(input int nf, input int kp_frame,
                              output int hi1, output int hi2, output int rise2);
        logic prev2;
        hi1 = 0; hi2 = 0; rise2 = 0;
        prev2 = bif.p2_o.coin;
        for (int f = 0; f < nf; f++) begin
            hi1 += int'(bif.p1_o.coin);
            hi2 += int'(bif.p2_o.coin);
            bif.vsync = 1'b1;
            step(1);
            if (bif.p2_o.coin && !prev2) rise2++;
            prev2 = bif.p2_o.coin;
            bif.vsync = 1'b0;
            for (int s = 0; s < 3; s++) begin
                if (f == kp_frame && s == 0) send_key(1'b0, SC_5, 1'b1);
                if (f == kp_frame && s == 1) send_key(1'b0, SC_5, 1'b0);
                step(1);
                if (bif.p2_o.coin && !prev2) rise2++;
                prev2 = bif.p2_o.coin;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif.ps2_key    = {1'b1, 1'b1, KEY_EXT, SC_UP};
        bif.joystick_0 = '0;
        bif.joystick_1 = '0;
        bif.vsync      = 1'b0;
        step(3);
        n_run++;
        if ({out_vec(), bif.pause_o} !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {out_vec(), bif.pause_o});
        end
        rst = 1'b0;
        step(4);
        n_run++;
        if ({out_vec(), bif.pause_o} !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_release_no_event: got %h expected 0", {out_vec(), bif.pause_o});
        end
    endtask

    task automatic test_arrow();
        send_key(KEY_EXT, SC_UP, 1'b1);
        step(1);
        n_run++;
        if (bif.p1_o.up !== 1'b0) begin
            n_fail++;
            $display("FAIL up_make_latency1: got %b expected 0", bif.p1_o.up);
        end
        step(1);
        n_run++;
        if (bif.p1_o.up !== 1'b1) begin
            n_fail++;
            $display("FAIL up_make_latency2: got %b expected 1", bif.p1_o.up);
        end
        send_key(KEY_EXT, SC_UP, 1'b0);
        step(1);
        n_run++;
        if (bif.p1_o.up !== 1'b1) begin
            n_fail++;
            $display("FAIL up_break_latency1: got %b expected 1", bif.p1_o.up);
        end
        step(1);
        n_run++;
        if (bif.p1_o.up !== 1'b0) begin
            n_fail++;
            $display("FAIL up_break_latency2: got %b expected 0", bif.p1_o.up);
        end
        send_key(1'b0, SC_UP, 1'b1);
        step(2);
        n_run++;
        if (out_vec() !== 20'h0) begin
            n_fail++;
            $display("FAIL up_nonext_ignored: got %h expected 0", out_vec());
        end
        send_key(1'b0, SC_UP, 1'b0);
        step(2);
    endtask

    task automatic test_keymap();
        logic        ext  [12];
        logic [7:0]  code [12];
        logic [19:0] vec  [12];
        logic [19:0] got;
        logic [19:0] want;
        ext  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        code = '{SC_LEFT, SC_CTRL, SC_ALT, SC_SPACE, SC_1, SC_2, SC_R, SC_G, SC_A, SC_9, SC_0, SC_DOWN};
        vec  = '{{9'h004, 9'h000, 2'b00}, {9'h010, 9'h000, 2'b00}, {9'h020, 9'h000, 2'b00},
                 {9'h040, 9'h000, 2'b00}, {9'h080, 9'h000, 2'b00}, {9'h000, 9'h080, 2'b00},
                 {9'h000, 9'h001, 2'b00}, {9'h000, 9'h008, 2'b00}, {9'h000, 9'h010, 2'b00},
                 {9'h000, 9'h000, 2'b01}, {9'h000, 9'h000, 2'b10}, {9'h002, 9'h000, 2'b00}};
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(vec[i]);
            send_key(ext[i], code[i], 1'b1);
            step(2);
            got = out_vec();
            want = exp_q.pop_front();
            n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL keymap_make[%0d] code %h: got %h expected %h", i, code[i], got, want);
            end
            exp_q.push_back(20'h0);
            send_key(ext[i], code[i], 1'b0);
            step(2);
            got = out_vec();
            want = exp_q.pop_front();
            n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL keymap_break[%0d] code %h: got %h expected %h", i, code[i], got, want);
            end
        end
    endtask

    task automatic test_joystick();
        logic [19:0] want;
        exp_q.push_back({9'h008, 9'h040, 2'b10});
        bif.joystick_0[JOY_R]   = 1'b1;
        bif.joystick_1[JOY_B3]  = 1'b1;
        bif.joystick_1[JOY_SVC] = 1'b1;
        step(1);
        want = exp_q.pop_front();
        n_run++;
        if (out_vec() !== want) begin
            n_fail++;
            $display("FAIL joystick_latency1: got %h expected %h", out_vec(), want);
        end
        bif.joystick_0 = '0;
        bif.joystick_1 = '0;
        step(1);
    endtask

    task automatic test_coin_key();
        int hi1, hi2, rise2, want;
        send_key(1'b0, SC_5, 1'b1);
        step(1);
        send_key(1'b0, SC_5, 1'b0);
        pulse_q.push_back(4);
        step(1);
        n_run++;
        if (bif.p1_o.coin !== 1'b1) begin
            n_fail++;
            $display("FAIL coin_key_start: got %b expected 1", bif.p1_o.coin);
        end
        run_frames(8, 1, hi1, hi2, rise2);
        want = pulse_q.pop_front();
        n_run++;
        if (hi1 !== want) begin
            n_fail++;
            $display("FAIL coin_key_width: got %0d frames expected %0d", hi1, want);
        end
        n_run++;
        if (bif.p1_o.coin !== 1'b0) begin
            n_fail++;
            $display("FAIL coin_key_end: got %b expected 0", bif.p1_o.coin);
        end
    endtask

    task automatic test_coin_hold();
        int hi1, hi2, rise2, want;
        bif.joystick_1[JOY_COIN] = 1'b1;
        pulse_q.push_back(4);
        step(1);
        run_frames(10, -1, hi1, hi2, rise2);
        want = pulse_q.pop_front();
        n_run++;
        if (hi2 !== want) begin
            n_fail++;
            $display("FAIL coin_hold_width: got %0d frames expected %0d", hi2, want);
        end
        n_run++;
        if (rise2 !== 0) begin
            n_fail++;
            $display("FAIL coin_hold_repulse: got %0d extra pulses expected 0", rise2);
        end
        bif.joystick_1[JOY_COIN] = 1'b0;
        step(2);
        bif.joystick_1[JOY_COIN] = 1'b1;
        pulse_q.push_back(4);
        step(1);
        n_run++;
        if (bif.p2_o.coin !== 1'b1) begin
            n_fail++;
            $display("FAIL coin_repress_start: got %b expected 1", bif.p2_o.coin);
        end
        run_frames(6, -1, hi1, hi2, rise2);
        want = pulse_q.pop_front();
        n_run++;
        if (hi2 !== want) begin
            n_fail++;
            $display("FAIL coin_repress_width: got %0d frames expected %0d", hi2, want);
        end
        bif.joystick_1[JOY_COIN] = 1'b0;
        step(1);
    endtask

    task automatic test_pause();
        send_key(1'b0, SC_P, 1'b1);
        step(1);
        bif.joystick_1[JOY_PAUSE] = 1'b1;
        step(3);
        n_run++;
        if (bif.pause_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_dual_press: got %b expected 1", bif.pause_o);
        end
        send_key(1'b0, SC_P, 1'b0);
        bif.joystick_1[JOY_PAUSE] = 1'b0;
        step(3);
        n_run++;
        if (bif.pause_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_release_hold: got %b expected 1", bif.pause_o);
        end
        bif.joystick_0[JOY_PAUSE] = 1'b1;
        step(2);
        n_run++;
        if (bif.pause_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_second_press: got %b expected 0", bif.pause_o);
        end
        bif.joystick_0[JOY_PAUSE] = 1'b0;
        step(2);
    endtask

    task automatic test_reset_mid();
        int hi1, hi2, rise2, want;
        bif.joystick_0[JOY_PAUSE] = 1'b1;
        step(2);
        bif.joystick_0[JOY_PAUSE] = 1'b0;
        bif.joystick_0[JOY_COIN]  = 1'b1;
        bif.joystick_0[JOY_U]     = 1'b1;
        bif.joystick_1[JOY_SVC]   = 1'b1;
        step(2);
        n_run++;
        if ({bif.p1_o, bif.service_o, bif.pause_o} !== {9'h101, 2'b10, 1'b1}) begin
            n_fail++;
            $display("FAIL pre_reset_state: got %h expected %h",
                     {bif.p1_o, bif.service_o, bif.pause_o}, {9'h101, 2'b10, 1'b1});
        end
        rst = 1'b1;
        step(1);
        n_run++;
        if ({out_vec(), bif.pause_o} !== 21'h0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: got %h expected 0", {out_vec(), bif.pause_o});
        end
        bif.joystick_0 = '0;
        bif.joystick_1 = '0;
        step(1);
        rst = 1'b0;
        step(2);
        n_run++;
        if (bif.p1_o.coin !== 1'b0) begin
            n_fail++;
            $display("FAIL coin_aborted: got %b expected 0", bif.p1_o.coin);
        end
        bif.joystick_0[JOY_U]    = 1'b1;
        bif.joystick_1[JOY_COIN] = 1'b1;
        pulse_q.push_back(4);
        step(1);
        n_run++;
        if ({bif.p1_o.up, bif.p2_o.coin} !== 2'b11) begin
            n_fail++;
            $display("FAIL resume_after_reset: got %b expected 11", {bif.p1_o.up, bif.p2_o.coin});
        end
        run_frames(6, -1, hi1, hi2, rise2);
        want = pulse_q.pop_front();
        n_run++;
        if (hi2 !== want) begin
            n_fail++;
            $display("FAIL resume_coin_width: got %0d frames expected %0d", hi2, want);
        end
        bif.joystick_0 = '0;
        bif.joystick_1 = '0;
        step(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_arrow();
        test_keymap();
        test_joystick();
        test_coin_key();
        test_coin_hold();
        test_pause();
        test_reset_mid();
        n_run++;
        if (pulse_q.size() + exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", pulse_q.size() + exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
